// File: rtl/sme_nlu_and.sv
`default_nettype none
// ============================================================================
// Module   : sme_nlu_and
// Function : Multi-cycle ISW masked-AND unit; one share pair and one random
//            word per cycle. Optional macro SME_NLU_ZEROIZE_EN clears share
//            state and out_rd on every return to IDLE.
// Revision : 1.0
// ============================================================================
module sme_nlu_and #(
   parameter int SMAX = 4,
   parameter int XLEN = 32
) (
   input  logic                 g_clk,
   input  logic                 g_resetn,
   input  logic                 flush,
   input  logic [3:0]           nshares,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SMAX*XLEN-1:0] in_rs1,
   input  logic [SMAX*XLEN-1:0] in_rs2,
   input  logic [3:0]           in_rd_addr,
   input  logic                 rng_valid,
   output logic                 rng_ready,
   input  logic [XLEN-1:0]      rng_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SMAX*XLEN-1:0] out_rd,
   output logic [3:0]           out_rd_addr
);

   localparam int             c_IW   = 5;
   localparam int             c_AW   = (SMAX > 2) ? $clog2(SMAX) : 1;
   localparam logic [c_IW-1:0] c_SMAX = c_IW'(SMAX);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PAIR = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [XLEN-1:0]       r_a [SMAX];
   logic [XLEN-1:0]       r_b [SMAX];
   logic [XLEN-1:0]       r_c [SMAX];
   logic [XLEN-1:0]       w_c_nxt [SMAX];
   logic [c_IW-1:0]       r_d, w_d_in;
   logic [c_AW-1:0]       r_i, r_j, w_i_nxt, w_j_nxt;
   logic [3:0]            r_addr;
   logic [SMAX*XLEN-1:0]  r_out, w_out_nxt;
   logic                  w_accept, w_last, w_load_out, w_to_idle;

   always_comb begin
      if (nshares < 4'd2)
         w_d_in = c_IW'(1);
      else if ({1'b0, nshares} > c_SMAX)
         w_d_in = c_SMAX;
      else
         w_d_in = {1'b0, nshares};
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      rng_ready   = 1'b0;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      w_i_nxt     = r_i;
      w_j_nxt     = r_j;
      w_c_nxt     = r_c;
      case (r_state)
         S_IDLE: begin
            in_ready = !flush;
            if (in_valid && !flush) begin
               w_accept    = 1'b1;
               w_i_nxt     = '0;
               w_j_nxt     = c_AW'(1);
               w_state_nxt = (w_d_in > c_IW'(1)) ? S_PAIR : S_DONE;
               for (int k = 0; k < SMAX; k++)
                  w_c_nxt[k] = (c_IW'(k) < w_d_in) ?
                               (in_rs1[k*XLEN +: XLEN] & in_rs2[k*XLEN +: XLEN]) : '0;
            end
         end
         S_PAIR: begin
            rng_ready = rng_valid && !flush;
            if (rng_valid && !flush) begin
               w_c_nxt[r_i] = r_c[r_i] ^ rng_data;
               w_c_nxt[r_j] = r_c[r_j] ^ (rng_data ^ (r_a[r_i] & r_b[r_j]))
                                        ^ (r_a[r_j] & r_b[r_i]);
               w_last = (c_IW'(r_i) + c_IW'(2) == r_d) && (c_IW'(r_j) + c_IW'(1) == r_d);
               // Last j of a row wraps to the first j of the next row.
               if (c_IW'(r_j) + c_IW'(1) == r_d) begin
                  w_i_nxt = r_i + c_AW'(1);
                  w_j_nxt = r_i + c_AW'(2);
               end else begin
                  w_j_nxt = r_j + c_AW'(1);
               end
               if (w_last)
                  w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (flush)
         w_state_nxt = S_IDLE;
   end

   always_comb begin
      w_out_nxt = '0;
      for (int k = 0; k < SMAX; k++)
         w_out_nxt[k*XLEN +: XLEN] = w_c_nxt[k];
   end

   assign w_load_out = (w_state_nxt == S_DONE) && (r_state != S_DONE);
   assign w_to_idle  = (w_state_nxt == S_IDLE) && (r_state != S_IDLE);

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         r_state <= S_IDLE;
         r_d     <= c_IW'(1);
         r_i     <= '0;
         r_j     <= c_AW'(1);
         r_addr  <= '0;
         r_out   <= '0;
         for (int k = 0; k < SMAX; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_c[k] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         r_i     <= w_i_nxt;
         r_j     <= w_j_nxt;
         for (int k = 0; k < SMAX; k++)
            r_c[k] <= w_c_nxt[k];
         if (w_accept) begin
            r_d    <= w_d_in;
            r_addr <= in_rd_addr;
            for (int k = 0; k < SMAX; k++) begin
               r_a[k] <= in_rs1[k*XLEN +: XLEN];
               r_b[k] <= in_rs2[k*XLEN +: XLEN];
            end
         end
         if (w_load_out)
            r_out <= w_out_nxt;
`ifdef SME_NLU_ZEROIZE_EN
         if (w_to_idle) begin
            r_out <= '0;
            for (int k = 0; k < SMAX; k++) begin
               r_a[k] <= '0;
               r_b[k] <= '0;
               r_c[k] <= '0;
            end
         end
`endif
      end
   end

`ifndef SME_NLU_ZEROIZE_EN
   logic w_unused;
   assign w_unused = w_to_idle;
`endif

   assign out_valid   = (r_state == S_DONE);
   assign out_rd      = r_out;
   assign out_rd_addr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_sme_nlu_and.sv
`default_nettype none
// Testbench for sme_nlu_and: randomized operands and random words checked
// against a share-level ISW reference and the unmasked AND.
module tb_sme_nlu_and;
   localparam int SMAX = 4;
   localparam int XLEN = 32;
   localparam int W    = SMAX * XLEN;

   logic          g_clk, g_resetn, flush, in_valid, in_ready;
   logic [3:0]    nshares, in_rd_addr, out_rd_addr;
   logic [W-1:0]  in_rs1, in_rs2, out_rd;
   logic          rng_valid, rng_ready, out_valid, out_ready;
   logic [XLEN-1:0] rng_data;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [XLEN-1:0] rq[$];

   sme_nlu_and #(.SMAX(SMAX), .XLEN(XLEN)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .nshares(nshares),
      .in_valid(in_valid), .in_ready(in_ready), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_rd_addr(in_rd_addr), .rng_valid(rng_valid), .rng_ready(rng_ready),
      .rng_data(rng_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_rd(out_rd), .out_rd_addr(out_rd_addr)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   function automatic int eff_d(input int nsh);
      if (nsh < 2) return 1;
      if (nsh > SMAX) return SMAX;
      return nsh;
   endfunction

   function automatic logic [W-1:0] rand_vec();
      logic [W-1:0] v;
      for (int k = 0; k < SMAX; k++) v[k*XLEN +: XLEN] = $urandom;
      return v;
   endfunction

   // ISW over the consumed random words, pairs in ascending (i,j) order.
   function automatic logic [W-1:0] isw_ref(input int d, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [XLEN-1:0] c [SMAX];
      logic [XLEN-1:0] r;
      logic [W-1:0]    o;
      int idx = 0;
      for (int k = 0; k < SMAX; k++) c[k] = (k < d) ? (a[k*XLEN +: XLEN] & b[k*XLEN +: XLEN]) : '0;
      for (int i = 0; i < d; i++)
         for (int j = i + 1; j < d; j++) begin
            r = (idx < rq.size()) ? rq[idx] : '0;
            idx++;
            c[i] = c[i] ^ r;
            c[j] = c[j] ^ r ^ (a[i*XLEN +: XLEN] & b[j*XLEN +: XLEN]) ^ (a[j*XLEN +: XLEN] & b[i*XLEN +: XLEN]);
         end
      for (int k = 0; k < SMAX; k++) o[k*XLEN +: XLEN] = c[k];
      return o;
   endfunction

   function automatic logic [XLEN-1:0] unmask(input int d, input logic [W-1:0] v);
      logic [XLEN-1:0] x = '0;
      for (int k = 0; k < d; k++) x ^= v[k*XLEN +: XLEN];
      return x;
   endfunction

   function automatic int exp_lat(input int d, input int mode);
      int p = d * (d - 1) / 2;
      int cyc = 1;
      int k = 0;
      if (mode != 1) return 1 + p;
      while (k < p) begin
         if (cyc % 2 == 1) k++;
         cyc++;
      end
      return cyc;
   endfunction

   // mode 0: rng always valid random; 1: valid on odd cycles; 2: always valid fixed word
   task automatic do_op(input logic [3:0] nsh, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] addr, input int mode, input logic [XLEN-1:0] fixr,
                        input int hold, output int lat, output int pulses, output logic [W-1:0] res,
                        output logic [3:0] raddr, output bit stable, output bit irlow,
                        output bit ir_after, output logic [W-1:0] rd_after, output bit acc);
      rq.delete();
      pulses = 0; lat = -1; stable = 1; irlow = 1; ir_after = 0; res = '0; raddr = '0; rd_after = '0;
      @(posedge g_clk); #1;
      in_valid = 1; nshares = nsh; in_rs1 = a; in_rs2 = b; in_rd_addr = addr;
      out_ready = 0; rng_valid = 0; flush = 0;
      @(negedge g_clk);
      acc = in_ready;
      for (int cyc = 1; cyc < 200 && lat < 0; cyc++) begin
         @(posedge g_clk); #1;
         in_valid = 0; nshares = 4'($urandom); in_rs1 = rand_vec(); in_rs2 = rand_vec();
         in_rd_addr = 4'($urandom);
         rng_valid = (mode == 1) ? (cyc % 2 == 1) : 1'b1;
         rng_data  = (mode == 2) ? fixr : $urandom;
         @(negedge g_clk);
         if (out_valid) lat = cyc;
         else if (rng_ready) begin
            pulses++;
            rq.push_back(rng_data);
         end
      end
      if (lat < 0) return;
      res = out_rd; raddr = out_rd_addr;
      for (int h = 0; h < hold; h++) begin
         @(posedge g_clk); #1;
         rng_valid = 1'($urandom); in_valid = 1;
         @(negedge g_clk);
         if (out_rd !== res || out_rd_addr !== raddr || out_valid !== 1'b1) stable = 0;
         if (in_ready) irlow = 0;
      end
      @(posedge g_clk); #1;
      out_ready = 1; in_valid = 1;
      @(negedge g_clk);
      if (in_ready) irlow = 0;
      @(posedge g_clk); #1;
      out_ready = 0; in_valid = 0; rng_valid = 0;
      @(negedge g_clk);
      ir_after = in_ready;
      rd_after = out_rd;
   endtask

   task automatic test_reset();
      g_resetn = 0; flush = 0; nshares = 0; in_valid = 0; in_rs1 = '0; in_rs2 = '0;
      in_rd_addr = 0; rng_valid = 1; rng_data = '0; out_ready = 0;
      #22;
      n_cmp += 5;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      if (rng_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rng_ready got=%b exp=0", rng_ready); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      if (out_rd !== '0) begin n_fail++; $display("FAIL reset_out_rd got=%h exp=0", out_rd); end
      if (out_rd_addr !== 4'd0) begin n_fail++; $display("FAIL reset_out_rd_addr got=%h exp=0", out_rd_addr); end
      @(posedge g_clk); #3; g_resetn = 1; rng_valid = 0;
   endtask

   task automatic test_vector_d2();
      int lat, pulses; logic [W-1:0] res, rda; logic [3:0] ra; bit st, il, ia, ac;
      logic [W-1:0] a = {64'h0, 32'h0F0F0F0F, 32'hF0F0F0F0};
      logic [W-1:0] b = {64'h0, 32'h00000000, 32'h12345678};
      do_op(4'd2, a, b, 4'd5, 2, 32'hDEADBEEF, 0, lat, pulses, res, ra, st, il, ia, rda, ac);
      n_cmp += 5;
      if (lat !== 2) begin n_fail++; $display("FAIL d2_latency got=%0d exp=2", lat); end
      if (res[31:0] !== 32'hCE9DEE9F) begin n_fail++; $display("FAIL d2_share0 got=%h exp=ce9dee9f", res[31:0]); end
      if (res[63:32] !== 32'hDCA9B8E7) begin n_fail++; $display("FAIL d2_share1 got=%h exp=dca9b8e7", res[63:32]); end
      if ((res[31:0] ^ res[63:32]) !== 32'h12345678) begin n_fail++; $display("FAIL d2_xor got=%h exp=12345678", res[31:0] ^ res[63:32]); end
      if (ra !== 4'd5) begin n_fail++; $display("FAIL d2_addr got=%h exp=5", ra); end
   endtask

   task automatic test_d1();
      int lat, pulses; logic [W-1:0] res, rda; logic [3:0] ra; bit st, il, ia, ac;
      logic [W-1:0] a = rand_vec();
      logic [W-1:0] b = rand_vec();
      a[31:0] = 32'hFFFF0000; b[31:0] = 32'h00FFFF00;
      do_op(4'd0, a, b, 4'd9, 0, '0, 0, lat, pulses, res, ra, st, il, ia, rda, ac);
      n_cmp += 3;
      if (pulses !== 0) begin n_fail++; $display("FAIL d1_rng_pulses got=%0d exp=0", pulses); end
      if (lat !== 1) begin n_fail++; $display("FAIL d1_latency got=%0d exp=1", lat); end
      if (res !== {96'h0, 32'h00FF0000}) begin n_fail++; $display("FAIL d1_result got=%h exp=%h", res, {96'h0, 32'h00FF0000}); end
   endtask

   task automatic test_d4_toggle();
      int lat, pulses; logic [W-1:0] res, rda, exp; logic [3:0] ra; bit st, il, ia, ac;
      logic [W-1:0] a = rand_vec();
      logic [W-1:0] b = rand_vec();
      do_op(4'd4, a, b, 4'd3, 1, '0, 0, lat, pulses, res, ra, st, il, ia, rda, ac);
      exp = isw_ref(4, a, b);
      n_cmp += 4;
      if (pulses !== 6) begin n_fail++; $display("FAIL d4t_rng_pulses got=%0d exp=6", pulses); end
      if (lat !== 12) begin n_fail++; $display("FAIL d4t_latency got=%0d exp=12", lat); end
      if (res !== exp) begin n_fail++; $display("FAIL d4t_result got=%h exp=%h", res, exp); end
      if (unmask(4, res) !== (unmask(4, a) & unmask(4, b))) begin
         n_fail++; $display("FAIL d4t_unmasked got=%h exp=%h", unmask(4, res), unmask(4, a) & unmask(4, b));
      end
   endtask

   task automatic test_hold_d3();
      int lat, pulses; logic [W-1:0] res, rda, exp; logic [3:0] ra; bit st, il, ia, ac;
      logic [W-1:0] a = rand_vec();
      logic [W-1:0] b = rand_vec();
      do_op(4'd3, a, b, 4'd12, 0, '0, 5, lat, pulses, res, ra, st, il, ia, rda, ac);
      exp = isw_ref(3, a, b);
      n_cmp += 5;
      if (res !== exp) begin n_fail++; $display("FAIL hold_result got=%h exp=%h", res, exp); end
      if (st !== 1'b1) begin n_fail++; $display("FAIL hold_stable got=%b exp=1", st); end
      if (il !== 1'b1) begin n_fail++; $display("FAIL hold_in_ready_low got=%b exp=1", il); end
      if (ia !== 1'b1) begin n_fail++; $display("FAIL hold_in_ready_after got=%b exp=1", ia); end
      if (ra !== 4'd12) begin n_fail++; $display("FAIL hold_addr got=%h exp=c", ra); end
   endtask

   task automatic test_random();
      int lat, pulses, d, mode; logic [W-1:0] res, rda, exp, a, b; logic [3:0] ra, addr, nsh;
      bit st, il, ia, ac;
      for (int t = 0; t < 16; t++) begin
         nsh = 4'($urandom_range(0, 15)); d = eff_d(int'(nsh)); mode = $urandom_range(0, 1);
         a = rand_vec(); b = rand_vec(); addr = 4'($urandom);
         do_op(nsh, a, b, addr, mode, '0, $urandom_range(0, 2), lat, pulses, res, ra, st, il, ia, rda, ac);
         exp = isw_ref(d, a, b);
         n_cmp += 6;
         if (ac !== 1'b1) begin n_fail++; $display("FAIL rnd_accept t=%0d got=%b exp=1", t, ac); end
         if (lat !== exp_lat(d, mode)) begin n_fail++; $display("FAIL rnd_latency t=%0d got=%0d exp=%0d", t, lat, exp_lat(d, mode)); end
         if (res !== exp) begin n_fail++; $display("FAIL rnd_result t=%0d d=%0d got=%h exp=%h", t, d, res, exp); end
         if (unmask(d, res) !== (unmask(d, a) & unmask(d, b))) begin
            n_fail++; $display("FAIL rnd_unmasked t=%0d got=%h exp=%h", t, unmask(d, res), unmask(d, a) & unmask(d, b));
         end
         if (ra !== addr) begin n_fail++; $display("FAIL rnd_addr t=%0d got=%h exp=%h", t, ra, addr); end
         if (ia !== 1'b1) begin n_fail++; $display("FAIL rnd_in_ready_after t=%0d got=%b exp=1", t, ia); end
`ifdef SME_NLU_ZEROIZE_EN
         n_cmp++;
         if (rda !== '0) begin n_fail++; $display("FAIL rnd_zeroize t=%0d got=%h exp=0", t, rda); end
`endif
      end
   endtask

   task automatic test_flush();
      bit seen = 0;
      @(posedge g_clk); #1;
      in_valid = 1; nshares = 4'd4; in_rs1 = rand_vec(); in_rs2 = rand_vec(); in_rd_addr = 4'd7;
      rng_valid = 1; rng_data = $urandom; out_ready = 0;
      @(posedge g_clk); #1; in_valid = 0; rng_data = $urandom;
      @(posedge g_clk); #1; flush = 1; rng_data = $urandom;
      @(negedge g_clk);
      n_cmp += 2;
      if (rng_ready !== 1'b0) begin n_fail++; $display("FAIL flush_rng_ready got=%b exp=0", rng_ready); end
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
      @(posedge g_clk); #1; flush = 0;
      @(negedge g_clk);
      n_cmp += 2;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle got=%b exp=1", in_ready); end
`ifdef SME_NLU_ZEROIZE_EN
      n_cmp++;
      if (out_rd !== '0) begin n_fail++; $display("FAIL flush_zeroize got=%h exp=0", out_rd); end
`endif
      for (int k = 0; k < 10; k++) begin
         @(negedge g_clk);
         if (out_valid || rng_ready) seen = 1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_quiet got=%b exp=0", seen); end
      rng_valid = 0;
   endtask

   task automatic test_async_reset();
      int lat, pulses; logic [W-1:0] res, rda, exp, a, b; logic [3:0] ra; bit st, il, ia, ac;
      @(posedge g_clk); #1;
      in_valid = 1; nshares = 4'd4; in_rs1 = rand_vec(); in_rs2 = rand_vec(); in_rd_addr = 4'd2;
      rng_valid = 1; rng_data = $urandom; out_ready = 0;
      @(posedge g_clk); #1; in_valid = 0;
      @(posedge g_clk); #3; g_resetn = 0;
      #1;
      n_cmp += 3;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready got=%b exp=1", in_ready); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_out_valid got=%b exp=0", out_valid); end
      if (rng_ready !== 1'b0) begin n_fail++; $display("FAIL areset_rng_ready got=%b exp=0", rng_ready); end
      @(posedge g_clk); #3; g_resetn = 1; rng_valid = 0;
      a = rand_vec(); b = rand_vec();
      do_op(4'd2, a, b, 4'd1, 0, '0, 0, lat, pulses, res, ra, st, il, ia, rda, ac);
      exp = isw_ref(2, a, b);
      n_cmp += 2;
      if (lat !== 2) begin n_fail++; $display("FAIL areset_next_latency got=%0d exp=2", lat); end
      if (res !== exp) begin n_fail++; $display("FAIL areset_next_result got=%h exp=%h", res, exp); end
   endtask

   initial begin
      test_reset();
      test_vector_d2();
      test_d1();
      test_d4_toggle();
      test_hold_d3();
      test_random();
      test_flush();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
